// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer:
// FSM state encoding, counter-width helper and parity polarity.
package sipo_pkg;

    // RECV: collecting data bits; PAR: waiting for the trailing parity bit
    typedef enum logic {
        RECV = 1'b0,
        PAR  = 1'b1
    } state_t;

    // Required XOR of data bits plus parity bit (even parity)
    localparam logic EVEN = 1'b0;

    // Bit counter width able to hold 0..w
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register for the deserializer: keeps a completed word
// (plus its parity flag) stable under backpressure and records dropped words.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              a word completed this cycle
//   din, pin          completed word and its parity-error flag
//   out_ready         consumer accepts po when out_valid is high
//   ovr_clr           clears the sticky overrun flag
//   po, par_err       held word and parity flag
//   out_valid         po holds an unconsumed word
//   overrun           sticky: a completed word was dropped
module sipo_hold_reg #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         pin,
    input  logic         out_ready,
    input  logic         ovr_clr,
    output logic [W-1:0] po,
    output logic         par_err,
    output logic         out_valid,
    output logic         overrun
);

    logic accept_c;
    logic drop_c;

    assign accept_c = out_valid && out_ready;
    assign drop_c   = load && out_valid && !out_ready;

    // Data/valid: a new word may load when the slot is empty or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            po        <= '0;
            par_err   <= 1'b0;
            out_valid <= 1'b0;
        end else if (load && (!out_valid || out_ready)) begin
            po        <= din;
            par_err   <= pin;
            out_valid <= 1'b1;
        end else if (accept_c) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun; a drop on the same edge as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer. Assembles W-bit words from a qualified
// LSB-first bit stream and hands them to a valid/ready holding register.
// Optional feature macro: SIPO_PARITY_EN -- a trailing even-parity bit follows
// each word and its check result is presented on par_err.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   si, si_valid   serial bit and its qualifier
//   flush          discard any partial word
//   po, out_valid  held parallel word and its valid flag
//   out_ready      consumer accept
//   overrun        sticky dropped-word flag, cleared by ovr_clr
//   busy           partial word in progress
//   par_err        parity mismatch for the word on po (0 without the feature)
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         si,
    input  logic         si_valid,
    input  logic         flush,
    output logic [W-1:0] po,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun,
    input  logic         ovr_clr,
    output logic         busy,
    output logic         par_err
);

    localparam int unsigned CNT_W = cnt_width(W);

    state_t           state, state_n;
    logic [W-1:0]     sr, sr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             busy_n;
    logic             load_c;
    logic [W-1:0]     word_c;
    logic             par_c;

    // State, shift register, counter and busy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RECV;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
        end
    end

    // Next-state, shift and word-completion logic; flush overrides si_valid
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        load_c  = 1'b0;
        word_c  = {si, sr[W-1:1]};
        par_c   = 1'b0;
        if (flush) begin
            cnt_n   = '0;
            state_n = RECV;
        end else if (si_valid) begin
            unique case (state)
                RECV: begin
                    sr_n = {si, sr[W-1:1]};
                    if (cnt == CNT_W'(W - 1)) begin
                        cnt_n = '0;
`ifdef SIPO_PARITY_EN
                        state_n = PAR;
`else
                        load_c  = 1'b1;
`endif
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                PAR: begin
                    // Data already sits in sr; this bit is parity only
                    word_c  = sr;
                    par_c   = ((^sr) ^ si) != EVEN;
                    load_c  = 1'b1;
                    state_n = RECV;
                end
                default: state_n = RECV;
            endcase
        end
        busy_n = (cnt_n != '0) || (state_n == PAR);
    end

    sipo_hold_reg #(
        .W(W)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .din       (word_c),
        .pin       (par_c),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .po        (po),
        .par_err   (par_err),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: tests push expected words, a negedge
// monitor pops and compares on every accepted output.
module tb_sipo_deser;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         si;
    logic         si_valid;
    logic         flush;
    logic [W-1:0] po;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         ovr_clr;
    logic         busy;
    logic         par_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W:0] sb_q[$];

    always #5 clk = ~clk;

    sipo_deser #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .si        (si),
        .si_valid  (si_valid),
        .flush     (flush),
        .po        (po),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .busy      (busy),
        .par_err   (par_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one qualified bit; returns 1 time unit after the sampling edge
    task automatic send_bit(input logic b);
        si       = b;
        si_valid = 1'b1;
        @(posedge clk);
        #1;
        si_valid = 1'b0;
        si       = 1'b0;
    endtask

    // Send a word LSB first; with parity on, a trailing parity bit follows
    task automatic send_word(input logic [W-1:0] w, input logic p);
        for (int i = 0; i < W; i++) send_bit(w[i]);
`ifdef SIPO_PARITY_EN
        send_bit(p);
`else
        if (p) $display("note: parity bit ignored in this build");
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got po=%b par_err=%b expected none", po, par_err);
            end else begin
                chk("sb_word", 32'({par_err, po}), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        si        = 1'b0;
        si_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        ovr_clr   = 1'b0;
        #2;
        chk("rst_po", 32'(po), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_par_err", 32'(par_err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Basic word: 0,1,0,1 -> 1010, valid for exactly one cycle
        sb_q.push_back({1'b0, 4'b1010});
        send_word(4'b1010, 1'b0);
        chk("basic_valid_rise", 32'(out_valid), 32'h1);
        idle(1);
        chk("basic_valid_fall", 32'(out_valid), 32'h0);

        // Gapped input: two idle cycles between bits 2 and 3
        sb_q.push_back({1'b0, 4'b1010});
        send_bit(1'b0);
        chk("gap_busy_bit1", 32'(busy), 32'h1);
        send_bit(1'b1);
        idle(2);
        chk("gap_busy_idle", 32'(busy), 32'h1);
        chk("gap_no_valid", 32'(out_valid), 32'h0);
        send_bit(1'b0);
        send_bit(1'b1);
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`endif
        chk("gap_busy_done", 32'(busy), 32'h0);
        chk("gap_valid", 32'(out_valid), 32'h1);
        idle(1);

        // Backpressure: second word dropped, first held
        out_ready = 1'b0;
        sb_q.push_back({1'b0, 4'b1010});
        send_word(4'b1010, 1'b0);
        send_word(4'b0110, 1'b0);
        chk("bp_po_held", 32'(po), 32'hA);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_overrun", 32'(overrun), 32'h1);
        ovr_clr = 1'b1;
        idle(1);
        ovr_clr = 1'b0;
        chk("bp_ovr_clr", 32'(overrun), 32'h0);
        out_ready = 1'b1;
        idle(1);
        chk("bp_drained", 32'(out_valid), 32'h0);

        // Back-to-back words with consumer always ready
        sb_q.push_back({1'b0, 4'b1010});
        sb_q.push_back({1'b0, 4'b0110});
        send_word(4'b1010, 1'b0);
        send_word(4'b0110, 1'b0);
        chk("b2b_po", 32'(po), 32'h6);
        chk("b2b_overrun", 32'(overrun), 32'h0);
        idle(1);

        // Flush with si_valid on the same edge discards the partial word
        send_bit(1'b0);
        send_bit(1'b0);
        si = 1'b1; si_valid = 1'b1; flush = 1'b1;
        idle(1);
        si = 1'b0; si_valid = 1'b0; flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_no_valid", 32'(out_valid), 32'h0);
        sb_q.push_back({1'b0, 4'b1111});
        send_word(4'b1111, 1'b0);
        idle(1);

        // Reset mid-word with a held word pending: everything clears
        out_ready = 1'b0;
        send_word(4'b1001, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_po", 32'(po), 32'h0);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.push_back({1'b0, 4'b0011});
        send_word(4'b0011, 1'b0);
        chk("post_rst_po", 32'(po), 32'h3);
        idle(1);

`ifdef SIPO_PARITY_EN
        // Parity: data 1,0,1,0 -> 0101; good then bad parity bit
        sb_q.push_back({1'b0, 4'b0101});
        for (int i = 0; i < 4; i++) send_bit(i[0] == 1'b0);
        chk("par_wait_valid", 32'(out_valid), 32'h0);
        chk("par_wait_busy", 32'(busy), 32'h1);
        send_bit(1'b0);
        chk("par_ok_valid", 32'(out_valid), 32'h1);
        chk("par_ok_err", 32'(par_err), 32'h0);
        idle(1);
        sb_q.push_back({1'b1, 4'b0101});
        for (int i = 0; i < 4; i++) send_bit(i[0] == 1'b0);
        send_bit(1'b1);
        chk("par_bad_err", 32'(par_err), 32'h1);
        idle(1);
`endif

        idle(3);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
